// File: rtl/uart_tx_fifo.sv
// UART transmitter with divisor baud generator, parity/stop options and TX FIFO.
// Define UART_TX_CTS_EN to gate frame starts on a synchronised cts_n.
module uart_tx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic [1:0]                    parity_type,
  input  logic                          stop_bits,
  input  logic                          wr_valid,
  input  logic [DATA_W-1:0]             wr_data,
  output logic                          wr_ready,
  input  logic                          cts_n,
  output logic                          data_tx,
  output logic                          active_flag,
  output logic                          done_flag,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(DATA_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]       r_wptr;
  logic [AW-1:0]       r_rptr;
  logic [CW-1:0]       r_count;
  logic [CW-1:0]       w_count_nxt;
  logic                r_wr_ready;

  logic [DATA_W-1:0]   r_shift;
  logic [DATA_W-1:0]   w_shift_nxt;
  logic [DIV_W-1:0]    r_baud_cnt;
  logic [DIV_W-1:0]    r_div;
  logic [BW-1:0]       r_bitcnt;
  logic                r_stopcnt;
  logic                r_par_en;
  logic                r_par_bit;
  logic                r_stop2;

  logic                r_tx;
  logic                r_active;
  logic                r_done;
  logic                w_tx_nxt;
  logic                w_active_nxt;
  logic                w_done_nxt;

  logic                w_push;
  logic                w_pop;
  logic                w_cts_ok;
  logic                w_can_start;
  logic                w_bit_end;
  logic                w_last_data;
  logic                w_stop_end;
  logic [DATA_W-1:0]   w_head;
  logic [DIV_W-1:0]    w_div_eff;

`ifdef UART_TX_CTS_EN
  logic r_cts_s1;
  logic r_cts_s2;

  // Reset to "blocked" so nothing leaves before the sampled line is known.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cts_s1 <= 1'b1;
      r_cts_s2 <= 1'b1;
    end else begin
      r_cts_s1 <= cts_n;
      r_cts_s2 <= r_cts_s1;
    end
  end

  assign w_cts_ok = ~r_cts_s2;
`else
  logic w_unused_cts;
  assign w_unused_cts = cts_n;
  assign w_cts_ok     = 1'b1;
`endif

  assign w_head      = r_mem[r_rptr];
  assign w_push      = wr_valid && r_wr_ready;
  assign w_can_start = (r_count != '0) && w_cts_ok;
  assign w_bit_end   = (r_baud_cnt == r_div - DIV_W'(1));
  assign w_last_data = (r_bitcnt == BW'(DATA_W - 1));
  assign w_stop_end  = (r_state == S_STOP) && w_bit_end &&
                       (!r_stop2 || r_stopcnt);
  assign w_pop       = w_can_start &&
                       ((r_state == S_IDLE) || w_stop_end);
  assign w_div_eff   = (baud_div == '0) ? DIV_W'(1) : baud_div;
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wptr] <= wr_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_wr_ready <= 1'b1;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count    <= w_count_nxt;
      r_wr_ready <= (w_count_nxt < CW'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_tx     <= 1'b1;
      r_active <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_tx     <= w_tx_nxt;
      r_active <= w_active_nxt;
      r_done   <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (1'b1)
      (r_state == S_IDLE):
        if (w_can_start) w_state_nxt = S_START;
      (r_state == S_START):
        if (w_bit_end) w_state_nxt = S_DATA;
      (r_state == S_DATA):
        if (w_bit_end && w_last_data)
          w_state_nxt = r_par_en ? S_PARITY : S_STOP;
      (r_state == S_PARITY):
        if (w_bit_end) w_state_nxt = S_STOP;
      (r_state == S_STOP):
        if (w_stop_end)
          w_state_nxt = w_can_start ? S_START : S_IDLE;
      default:
        w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_tx_nxt     = 1'b1;
    w_active_nxt = (w_state_nxt != S_IDLE);
    w_done_nxt   = w_stop_end;
    unique case (1'b1)
      (w_state_nxt == S_START):  w_tx_nxt = 1'b0;
      (w_state_nxt == S_DATA):   w_tx_nxt = w_shift_nxt[0];
      (w_state_nxt == S_PARITY): w_tx_nxt = r_par_bit;
      default:                   w_tx_nxt = 1'b1;
    endcase
  end

  always_comb begin
    w_shift_nxt = r_shift;
    if (w_pop)
      w_shift_nxt = w_head;
    else if ((r_state == S_DATA) && w_bit_end)
      w_shift_nxt = r_shift >> 1;
  end

  // Frame configuration is captured at pop so mid-frame changes wait.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_shift    <= '0;
      r_baud_cnt <= '0;
      r_div      <= DIV_W'(1);
      r_bitcnt   <= '0;
      r_stopcnt  <= 1'b0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_stop2    <= 1'b0;
    end else begin
      r_shift <= w_shift_nxt;
      if ((r_state == S_IDLE) || w_bit_end)
        r_baud_cnt <= '0;
      else
        r_baud_cnt <= r_baud_cnt + DIV_W'(1);
      if (w_pop) begin
        r_div     <= w_div_eff;
        r_bitcnt  <= '0;
        r_stopcnt <= 1'b0;
        r_par_en  <= ^parity_type;
        r_par_bit <= (^w_head) ^ (parity_type == 2'b01);
        r_stop2   <= stop_bits;
      end else begin
        if ((r_state == S_DATA) && w_bit_end)
          r_bitcnt <= r_bitcnt + BW'(1);
        if ((r_state == S_STOP) && w_bit_end)
          r_stopcnt <= 1'b1;
      end
    end
  end

  assign data_tx     = r_tx;
  assign active_flag = r_active;
  assign done_flag   = r_done;
  assign wr_ready    = r_wr_ready;
  assign fifo_count  = r_count;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo (8-bit data, 16-entry FIFO).
// CTS gating is exercised when UART_TX_CTS_EN is defined.
module tb_uart_tx_fifo;

  logic        clock;
  logic        reset_n;
  logic [15:0] baud_div;
  logic [1:0]  parity_type;
  logic        stop_bits;
  logic        wr_valid;
  logic [7:0]  wr_data;
  logic        wr_ready;
  logic        cts_n;
  logic        data_tx;
  logic        active_flag;
  logic        done_flag;
  logic [4:0]  fifo_count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] words [18];

  uart_tx_fifo dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .baud_div    (baud_div),
    .parity_type (parity_type),
    .stop_bits   (stop_bits),
    .wr_valid    (wr_valid),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .cts_n       (cts_n),
    .data_tx     (data_tx),
    .active_flag (active_flag),
    .done_flag   (done_flag),
    .fifo_count  (fifo_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] d);
    @(negedge clock);
    wr_valid = 1'b1;
    wr_data  = d;
    @(posedge clock);
    #1;
    wr_valid = 1'b0;
  endtask

  // Call just after the edge on which the start bit begins.
  task automatic check_frame(input string tag, input logic [11:0] bits,
                             input int n, input int d, input bit more);
    for (int k = 0; k < n; k++) begin
      #1;
      check($sformatf("%s_b%0d", tag, k), 32'(data_tx), 32'(bits[k]));
      if (k == 0) check($sformatf("%s_act", tag), 32'(active_flag), 1);
      repeat (d) @(posedge clock);
    end
    #1;
    check($sformatf("%s_done", tag), 32'(done_flag), 1);
    check($sformatf("%s_act_end", tag), 32'(active_flag), 32'(more));
    check($sformatf("%s_tx_end", tag), 32'(data_tx), 32'(!more));
  endtask

  function automatic logic [11:0] frm8n1(input logic [7:0] d);
    return {2'b00, 1'b1, d, 1'b0};
  endfunction

  initial begin
    reset_n     = 1'b0;
    baud_div    = 16'd4;
    parity_type = 2'b00;
    stop_bits   = 1'b0;
    wr_valid    = 1'b0;
    wr_data     = 8'h00;
    cts_n       = 1'b0;
    for (int i = 0; i < 18; i++) words[i] = 8'(i * 13 + 1);

    repeat (3) @(posedge clock);
    #1;
    check("rst_tx", 32'(data_tx), 1);
    check("rst_act", 32'(active_flag), 0);
    check("rst_done", 32'(done_flag), 0);
    check("rst_ready", 32'(wr_ready), 1);
    check("rst_count", 32'(fifo_count), 0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (4) @(posedge clock);
    #1;

    // reset in the middle of a frame
    wr(8'h11);
    wr(8'h22);
    wr(8'h33);
    repeat (5) @(posedge clock);
    #1;
    check("t1_pre_act", 32'(active_flag), 1);
    check("t1_pre_count", 32'(fifo_count), 2);
    #1;
    reset_n = 1'b0;
    #1;
    check("t1_tx", 32'(data_tx), 1);
    check("t1_act", 32'(active_flag), 0);
    check("t1_count", 32'(fifo_count), 0);
    check("t1_ready", 32'(wr_ready), 1);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (4) @(posedge clock);
    #1;

    // 0xA5, 8N1, 4 clocks per bit
    baud_div = 16'd4;
    wr(8'hA5);
    check("t2_lat_tx", 32'(data_tx), 1);
    check("t2_lat_count", 32'(fifo_count), 1);
    @(posedge clock);
    check_frame("t2", 12'b00_1101001010, 10, 4, 1'b0);
    @(posedge clock);
    #1;
    check("t2_done_clr", 32'(done_flag), 0);

    // 0x07 even parity, two stop bits
    baud_div    = 16'd2;
    parity_type = 2'b10;
    stop_bits   = 1'b1;
    wr(8'h07);
    @(posedge clock);
    check_frame("t3e", 12'b111000001110, 12, 2, 1'b0);
    // 0x07 odd parity, one stop bit
    parity_type = 2'b01;
    stop_bits   = 1'b0;
    wr(8'h07);
    @(posedge clock);
    check_frame("t3o", 12'b010000001110, 11, 2, 1'b0);

    // divisor 0 behaves as 1
    baud_div    = 16'd0;
    parity_type = 2'b00;
    wr(8'h3C);
    @(posedge clock);
    check_frame("t5", 12'b001001111000, 10, 1, 1'b0);
    @(posedge clock);
    #1;
    check("t5_done_clr", 32'(done_flag), 0);

    // fill FIFO behind a slow frame, then drain back-to-back at 1 clk/bit
    baud_div = 16'd100;
    @(negedge clock);
    wr_valid = 1'b1;
    for (int i = 0; i < 18; i++) begin
      wr_data = words[i];
      @(posedge clock);
      #1;
      if (i == 15) begin
        check("t4_ready15", 32'(wr_ready), 1);
        check("t4_count15", 32'(fifo_count), 15);
      end
      if (i == 16) begin
        check("t4_ready16", 32'(wr_ready), 0);
        check("t4_count16", 32'(fifo_count), 16);
      end
    end
    wr_valid = 1'b0;
    baud_div = 16'd1;
    check("t4_count_full", 32'(fifo_count), 16);
    for (int i = 0; i < 1500; i++) begin
      @(posedge clock);
      #1;
      if (done_flag) break;
    end
    check("t4_first_done", 32'(done_flag), 1);
    check("t4_gapless_act", 32'(active_flag), 1);
    check("t4_gapless_tx", 32'(data_tx), 0);
    check("t4_count_after", 32'(fifo_count), 15);
    for (int j = 1; j <= 16; j++)
      check_frame($sformatf("t4_f%0d", j), frm8n1(words[j]), 10, 1, j < 16);
    @(posedge clock);
    #1;
    check("t4_empty", 32'(fifo_count), 0);
    check("t4_ready_end", 32'(wr_ready), 1);

`ifdef UART_TX_CTS_EN
    begin
      int lat;
      lat = 0;
      cts_n = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      wr(8'h3C);
      repeat (10) @(posedge clock);
      #1;
      check("t6_blocked_tx", 32'(data_tx), 1);
      check("t6_blocked_cnt", 32'(fifo_count), 1);
      cts_n = 1'b0;
      for (int i = 1; i <= 8; i++) begin
        @(posedge clock);
        #1;
        if (!data_tx) begin
          lat = i;
          break;
        end
      end
      check("t6_latency_ok", 32'(lat >= 3 && lat <= 4), 1);
      repeat (3) @(posedge clock);
      cts_n = 1'b1;
      for (int i = 0; i < 200; i++) begin
        @(posedge clock);
        #1;
        if (done_flag) break;
      end
      check("t6_done", 32'(done_flag), 1);
      check("t6_count", 32'(fifo_count), 0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
